apb_completer_regfile: RTL and testbench

- APB completer (slave) end of the team's APB link: accepts SETUP/ACCESS transfers from an APB requester and services them from an internal register file.
- Inserts a programmable number of wait states and flags out-of-range addresses with pslverr.
- The top register is a read-only counter of completed transfers, giving the requester side a checkable target.

---
 rtl/apb_completer_regfile_if.sv | 24 ++
 rtl/apb_completer_regfile.sv | 105 ++++++++++
 tb/tb_apb_completer_regfile.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_completer_regfile_if.sv
// APB bus between a requester and the register-file completer.
interface apb_completer_regfile_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_completer_regfile.sv
// APB completer serving a small register file with fixed wait states;
// the top register is a read-only count of committed transfers.
module apb_completer_regfile #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    apb_completer_regfile_if.slave  apb
);
    localparam logic [ADDR_W-1:0] CNT_ADDR  = ADDR_W'(NUM_REGS - 1);
    localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        wait_reg, wait_next;
    logic [ADDR_W-1:0] addr_reg;
    logic              write_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] cnt_reg;
    logic [DATA_W-1:0] regs_reg [NUM_REGS-1];
    logic              latch, commit, done, rw_hit, cnt_hit;

    assign rw_hit  = addr_reg < CNT_ADDR;
    assign cnt_hit = addr_reg == CNT_ADDR;
    assign done    = (state_reg == ACCESS) && (wait_reg == 4'd0);

    always_comb begin
        state_next = state_reg;
        wait_next  = wait_reg;
        latch      = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (apb.psel && !apb.penable) begin
                    state_next = SETUP;
                    latch      = 1'b1;
                    wait_next  = WAIT_INIT;
                end
            end
            SETUP: state_next = ACCESS;
            ACCESS: begin
                // Losing psel mid-access abandons the transfer without side effects.
                if (!apb.psel) begin
                    state_next = IDLE;
                end else if (wait_reg != 4'd0) begin
                    wait_next = wait_reg - 4'd1;
                end else begin
                    commit = 1'b1;
                    if (apb.penable) begin
                        state_next = IDLE;
                    end else begin
                        state_next = SETUP;
                        latch      = 1'b1;
                        wait_next  = WAIT_INIT;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        apb.pready  = done;
        apb.pslverr = 1'b0;
        apb.prdata  = '0;
        if (done) begin
            if (write_reg)    apb.pslverr = !rw_hit;
            else if (rw_hit)  apb.prdata  = regs_reg[addr_reg];
            else if (cnt_hit) apb.prdata  = cnt_reg;
            else              apb.pslverr = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            wait_reg  <= '0;
            addr_reg  <= '0;
            write_reg <= 1'b0;
            wdata_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            if (latch) begin
                addr_reg  <= apb.paddr;
                write_reg <= apb.pwrite;
                wdata_reg <= apb.pwdata;
            end
            if (commit) cnt_reg <= cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS - 1; i++) regs_reg[i] <= '0;
        end else if (commit && write_reg && rw_hit) begin
            regs_reg[addr_reg] <= wdata_reg;
        end
    end
endmodule

// File: tb/tb_apb_completer_regfile.sv
// Directed bench: three completers (WAIT_CYCLES 1, 0, 3) share one bus, each with its own psel.
module tb_apb_completer_regfile;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] psel_v;
    logic       penable, pwrite;
    logic [3:0] paddr;
    logic [7:0] pwdata;
    logic [2:0] pready_v, pslverr_v;
    logic [7:0] prdata_v [3];
    int checks = 0;
    int passed = 0;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        apb_completer_regfile_if #(.ADDR_W(4), .DATA_W(8)) bus ();
        assign bus.psel      = psel_v[gi];
        assign bus.penable   = penable;
        assign bus.pwrite    = pwrite;
        assign bus.paddr     = paddr;
        assign bus.pwdata    = pwdata;
        assign pready_v[gi]  = bus.pready;
        assign pslverr_v[gi] = bus.pslverr;
        assign prdata_v[gi]  = bus.prdata;
        apb_completer_regfile #(
            .ADDR_W(4), .DATA_W(8), .NUM_REGS(12),
            .WAIT_CYCLES(gi == 0 ? 1 : (gi == 1 ? 0 : 3))
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .apb (bus)
        );
    end

    // One complete transfer; nwait counts penable cycles with pready=0
    // (the completer's SETUP cycle plus its wait states).
    task automatic xfer(input int sel, input logic wr, input logic [3:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic err, output int nwait);
        bit fin;
        fin = 1'b0;
        @(posedge clk); #1;
        psel_v = 3'b000; psel_v[sel] = 1'b1;
        penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        nwait = 0; rd = '0; err = 1'b0;
        while (!fin) begin
            @(negedge clk);
            if (pready_v[sel]) begin
                rd = prdata_v[sel]; err = pslverr_v[sel]; fin = 1'b1;
            end else begin
                checks++;
                if (prdata_v[sel] !== 8'h00 || pslverr_v[sel] !== 1'b0)
                    $display("FAIL wait_outputs: prdata=%0h pslverr=%0b, expected 0/0", prdata_v[sel], pslverr_v[sel]);
                else passed++;
                nwait++;
                if (nwait > 40) begin
                    checks++;
                    $display("FAIL pready_timeout: no pready after %0d cycles, expected within 16", nwait);
                    fin = 1'b1;
                end else begin
                    @(posedge clk); #1;
                end
            end
        end
        @(posedge clk); #1;
        psel_v = 3'b000; penable = 1'b0;
        $display("xfer dut%0d %s addr=%0d wdata=%0h -> rdata=%0h err=%0b waits=%0d",
                 sel, wr ? "WR" : "RD", a, d, rd, err, nwait);
    endtask

    task automatic test_reset();
        rst = 1'b0; psel_v = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (pready_v !== 3'b000) $display("FAIL reset_pready: got %b expected 000", pready_v); else passed++;
        checks++; if (pslverr_v !== 3'b000) $display("FAIL reset_pslverr: got %b expected 000", pslverr_v); else passed++;
        checks++; if ({prdata_v[0], prdata_v[1], prdata_v[2]} !== 24'h0)
            $display("FAIL reset_prdata: got %0h/%0h/%0h expected 0", prdata_v[0], prdata_v[1], prdata_v[2]); else passed++;
        @(posedge clk); #1; rst = 1'b1;
        // penable high while idle must not start a transfer
        psel_v = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 4'd3; pwdata = 8'hEE;
        repeat (2) begin
            @(negedge clk);
            checks++; if (pready_v[0] !== 1'b0) $display("FAIL idle_penable: pready=%b expected 0", pready_v[0]); else passed++;
        end
        @(posedge clk); #1; psel_v = 3'b000; penable = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] rd; logic err; int nw;
        xfer(0, 1'b1, 4'd3, 8'hA5, rd, err, nw);
        checks++; if (nw !== 2) $display("FAIL basic_wr_waits: got %0d expected 2", nw); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL basic_wr_err: got %b expected 0", err); else passed++;
        xfer(0, 1'b0, 4'd3, 8'h00, rd, err, nw);
        checks++; if (rd !== 8'hA5) $display("FAIL basic_rd_data: got %0h expected a5", rd); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL basic_rd_err: got %b expected 0", err); else passed++;
        checks++; if (nw !== 2) $display("FAIL basic_rd_waits: got %0d expected 2", nw); else passed++;
        xfer(0, 1'b0, 4'd11, 8'h00, rd, err, nw);
        checks++; if (rd !== 8'h02) $display("FAIL basic_cnt: got %0h expected 02", rd); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd; logic err; int nw;
        @(posedge clk); #1;
        psel_v = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 4'd0; pwdata = 8'h11;
        @(posedge clk); #1; penable = 1'b1;
        @(negedge clk);
        checks++; if (pready_v[1] !== 1'b0) $display("FAIL b2b_setup1: pready=%b expected 0", pready_v[1]); else passed++;
        // Second transfer's setup overlaps the first transfer's completing cycle.
        @(posedge clk); #1; penable = 1'b0; paddr = 4'd1; pwdata = 8'h22;
        @(negedge clk);
        checks++; if (pready_v[1] !== 1'b1) $display("FAIL b2b_done1: pready=%b expected 1", pready_v[1]); else passed++;
        @(posedge clk); #1; penable = 1'b1;
        @(negedge clk);
        checks++; if (pready_v[1] !== 1'b0) $display("FAIL b2b_setup2: pready=%b expected 0", pready_v[1]); else passed++;
        @(posedge clk);
        @(negedge clk);
        checks++; if (pready_v[1] !== 1'b1 || pslverr_v[1] !== 1'b0)
            $display("FAIL b2b_done2: pready=%b pslverr=%b expected 1/0", pready_v[1], pslverr_v[1]); else passed++;
        @(posedge clk); #1; psel_v = 3'b000; penable = 1'b0;
        $display("xfer dut1 back-to-back WR addr0=11 addr1=22");
        xfer(1, 1'b0, 4'd0, 8'h00, rd, err, nw);
        checks++; if (rd !== 8'h11) $display("FAIL b2b_rd0: got %0h expected 11", rd); else passed++;
        checks++; if (nw !== 1) $display("FAIL b2b_zero_wait: got %0d expected 1", nw); else passed++;
        xfer(1, 1'b0, 4'd1, 8'h00, rd, err, nw);
        checks++; if (rd !== 8'h22) $display("FAIL b2b_rd1: got %0h expected 22", rd); else passed++;
    endtask

    task automatic test_errors();
        logic [7:0] rd; logic err; int nw;
        xfer(0, 1'b1, 4'd11, 8'hFF, rd, err, nw);
        checks++; if (err !== 1'b1) $display("FAIL err_wr_cnt: pslverr=%b expected 1", err); else passed++;
        xfer(0, 1'b0, 4'd13, 8'h00, rd, err, nw);
        checks++; if (err !== 1'b1) $display("FAIL err_rd_unmapped: pslverr=%b expected 1", err); else passed++;
        checks++; if (rd !== 8'h00) $display("FAIL err_rd_data: got %0h expected 00", rd); else passed++;
        xfer(0, 1'b0, 4'd11, 8'h00, rd, err, nw);
        checks++; if (rd !== 8'h05 || err !== 1'b0) $display("FAIL err_cnt: got %0h/%b expected 05/0", rd, err); else passed++;
    endtask

    task automatic test_wrap();
        logic [7:0] rd; logic err; int nw;
        // dut0 has completed 6 transfers; 250 more brings the total to 256.
        for (int i = 0; i < 250; i++) xfer(0, 1'b1, 4'd5, 8'(i), rd, err, nw);
        xfer(0, 1'b0, 4'd11, 8'h00, rd, err, nw);
        checks++; if (rd !== 8'h00) $display("FAIL wrap_cnt: got %0h expected 00", rd); else passed++;
        xfer(0, 1'b0, 4'd5, 8'h00, rd, err, nw);
        checks++; if (rd !== 8'hF9) $display("FAIL wrap_last_wr: got %0h expected f9", rd); else passed++;
    endtask

    task automatic test_abort();
        logic [7:0] rd; logic err; int nw;
        @(posedge clk); #1;
        psel_v = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 4'd2; pwdata = 8'h5A;
        @(posedge clk); #1; penable = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; psel_v = 3'b000; penable = 1'b0;
        @(negedge clk);
        checks++; if (pready_v[2] !== 1'b0) $display("FAIL abort_pready: got %b expected 0", pready_v[2]); else passed++;
        @(negedge clk);
        checks++; if (pready_v[2] !== 1'b0) $display("FAIL abort_idle: got %b expected 0", pready_v[2]); else passed++;
        $display("xfer dut2 WR addr=2 wdata=5a aborted");
        xfer(2, 1'b0, 4'd2, 8'h00, rd, err, nw);
        checks++; if (rd !== 8'h00) $display("FAIL abort_no_write: got %0h expected 00", rd); else passed++;
        checks++; if (nw !== 4) $display("FAIL abort_next_waits: got %0d expected 4", nw); else passed++;
        xfer(2, 1'b0, 4'd11, 8'h00, rd, err, nw);
        checks++; if (rd !== 8'h01) $display("FAIL abort_cnt: got %0h expected 01", rd); else passed++;
    endtask

    task automatic test_async_reset();
        logic [7:0] rd; logic err; int nw;
        // Reset while dut0 is presenting read data.
        @(posedge clk); #1;
        psel_v = 3'b001; penable = 1'b0; pwrite = 1'b0; paddr = 4'd3;
        @(posedge clk); #1; penable = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (pready_v[0] !== 1'b1 || prdata_v[0] !== 8'hA5)
            $display("FAIL rst_pre_read: got %b/%0h expected 1/a5", pready_v[0], prdata_v[0]); else passed++;
        #1 rst = 1'b0;
        #1;
        checks++; if (pready_v[0] !== 1'b0 || prdata_v[0] !== 8'h00)
            $display("FAIL rst_async_read: got %b/%0h expected 0/00", pready_v[0], prdata_v[0]); else passed++;
        @(posedge clk); #1; psel_v = 3'b000; penable = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        // Reset in the middle of dut2's wait states.
        @(posedge clk); #1;
        psel_v = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 4'd4; pwdata = 8'h77;
        @(posedge clk); #1; penable = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (pready_v !== 3'b000 || pslverr_v !== 3'b000 || prdata_v[2] !== 8'h00)
            $display("FAIL rst_async_wait: pready=%b pslverr=%b prdata=%0h expected 0", pready_v, pslverr_v, prdata_v[2]); else passed++;
        @(posedge clk); #1; psel_v = 3'b000; penable = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        xfer(2, 1'b0, 4'd4, 8'h00, rd, err, nw);
        checks++; if (rd !== 8'h00) $display("FAIL rst_no_write: got %0h expected 00", rd); else passed++;
        xfer(2, 1'b0, 4'd11, 8'h00, rd, err, nw);
        checks++; if (rd !== 8'h01) $display("FAIL rst_cnt: got %0h expected 01", rd); else passed++;
        xfer(0, 1'b0, 4'd3, 8'h00, rd, err, nw);
        checks++; if (rd !== 8'h00) $display("FAIL rst_regs_cleared: got %0h expected 00", rd); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_errors();
        test_wrap();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
